// File: rtl/siso_tx_arbiter.sv
// ----------------------------------------------------------------------------
// siso_tx_arbiter
//
// Two-requester scheduler for one shared serial-out shift register. Each
// requester offers a WIDTH-bit word through a req/ack handshake. Round-robin
// arbitration in IDLE picks a requester. Its word is loaded on the ack edge
// and shifted out MSB first, one bit per clock, with sof/eof frame markers.
// After each frame the block forces GAP_CYCLES idle cycles.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req0/data0   requester 0 request and word (word stable while req0 high)
//   ack0         requester 0 grant pulse; data0 is captured on this edge
//   req1/data1   requester 1 request and word (word stable while req1 high)
//   ack1         requester 1 grant pulse; data1 is captured on this edge
//   sout         serial data bit, MSB first, 0 when sout_valid is low
//   sout_valid   sout carries a data bit this cycle
//   sof / eof    first / last bit of a frame
//   sout_id      requester owning the current (or most recent) frame
//   busy         block is not in IDLE
// ----------------------------------------------------------------------------
module siso_tx_arbiter #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             eof,
    output logic             sout_id,
    output logic             busy
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
    // Only compared while in GAP, which is never entered when GAP_CYCLES is 0.
    localparam logic [3:0]     LAST_GAP = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_n;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] sreg_n;
    logic [CW-1:0]    bit_cnt_r;
    logic [CW-1:0]    bit_cnt_n;
    logic [3:0]       gap_cnt_r;
    logic [3:0]       gap_cnt_n;
    logic             last_grant_r;
    logic             last_grant_n;
    logic             cur_id_r;
    logic             cur_id_n;
    logic             grant_s;

    // Round-robin pick: on contention the requester not served last time wins.
    function automatic logic pick_grant(input logic r0, input logic r1,
                                        input logic last);
        logic g;
        if (r0 && r1) begin
            g = ~last;
        end else if (r1) begin
            g = 1'b1;
        end else begin
            g = 1'b0;
        end
        return g;
    endfunction

    // State and datapath registers; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sreg_r       <= '0;
            bit_cnt_r    <= '0;
            gap_cnt_r    <= 4'd0;
            last_grant_r <= 1'b1;
            cur_id_r     <= 1'b0;
        end else begin
            state_r      <= state_n;
            sreg_r       <= sreg_n;
            bit_cnt_r    <= bit_cnt_n;
            gap_cnt_r    <= gap_cnt_n;
            last_grant_r <= last_grant_n;
            cur_id_r     <= cur_id_n;
        end
    end

    // Next-state logic, arbitration and the combinational ack pulses.
    always_comb begin
        state_n      = state_r;
        sreg_n       = sreg_r;
        bit_cnt_n    = bit_cnt_r;
        gap_cnt_n    = gap_cnt_r;
        last_grant_n = last_grant_r;
        cur_id_n     = cur_id_r;
        ack0         = 1'b0;
        ack1         = 1'b0;
        grant_s      = pick_grant(req0, req1, last_grant_r);

        case (state_r)
            ST_IDLE: begin
                // ack must stay low while rst is high: the load would be discarded.
                if (!rst && (req0 || req1)) begin
                    ack0         = ~grant_s;
                    ack1         = grant_s;
                    sreg_n       = grant_s ? data1 : data0;
                    cur_id_n     = grant_s;
                    last_grant_n = grant_s;
                    bit_cnt_n    = '0;
                    state_n      = ST_SHIFT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sreg_n    = {sreg_r[WIDTH-2:0], 1'b0};
                bit_cnt_n = bit_cnt_r + CW'(1);
                if (bit_cnt_r == LAST_BIT) begin
                    if (GAP_CYCLES > 0) begin
                        state_n   = ST_GAP;
                        gap_cnt_n = 4'd0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_SHIFT;
                end
            end
            ST_GAP: begin
                gap_cnt_n = gap_cnt_r + 4'd1;
                if (gap_cnt_r == LAST_GAP) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_GAP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Link outputs decoded purely from registered state.
    always_comb begin
        sout_id = cur_id_r;
        busy    = (state_r != ST_IDLE);
        if (state_r == ST_SHIFT) begin
            sout       = sreg_r[WIDTH-1];
            sout_valid = 1'b1;
            sof        = (bit_cnt_r == '0);
            eof        = (bit_cnt_r == LAST_BIT);
        end else begin
            sout       = 1'b0;
            sout_valid = 1'b0;
            sof        = 1'b0;
            eof        = 1'b0;
        end
    end

endmodule

// File: tb/tb_siso_tx_arbiter.sv
module tb_siso_tx_arbiter;

    localparam int W = 4;
    localparam int G = 1;
    localparam int PERIOD = 1 + W + G;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [W-1:0] data0 = '0;
    logic [W-1:0] data1 = '0;
    logic ack0, ack1, sout, sout_valid, sof, eof, sout_id, busy;

    siso_tx_arbiter #(.WIDTH(W), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .sout(sout), .sout_valid(sout_valid), .sof(sof), .eof(eof),
        .sout_id(sout_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the link is a resource that is free from free_cyc on.
    int   cyc = 0;
    int   free_cyc = 0;
    logic last_g = 1'b1;
    logic cur_id_m = 1'b0;
    logic exp_busy = 1'b0;
    logic exp_id = 1'b0;
    int   granted = -1;

    typedef struct { int c; logic id; } ack_t;
    typedef struct { int c; logic id; logic [W-1:0] d; } frame_t;
    ack_t   ackq[$];
    frame_t frameq[$];
    int     obs_id[$];
    int     obs_cyc[$];
    logic [W-1:0] last_data = '0;
    bit     mon_on = 1'b0;

    // Stimulus policy
    logic pend0 = 1'b0, pend1 = 1'b0, rep0 = 1'b0, rep1 = 1'b0;
    bit   gr0 = 1'b0, gr1 = 1'b0;
    bit   rnd = 1'b0;
    bit   force_rst = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of one cycle: called once the inputs for the cycle are applied.
    task automatic model_eval();
        logic g;
        exp_busy = (cyc < free_cyc);
        exp_id   = cur_id_m;
        granted  = -1;
        if (rst) begin
            free_cyc = cyc + 1;
            last_g   = 1'b1;
            cur_id_m = 1'b0;
        end else if (cyc >= free_cyc && (req0 || req1)) begin
            g = (req0 && req1) ? ~last_g : (req0 ? 1'b0 : 1'b1);
            ackq.push_back('{c: cyc, id: g});
            frameq.push_back('{c: cyc + 1, id: g, d: (g ? data1 : data0)});
            last_g   = g;
            cur_id_m = g;
            free_cyc = cyc + PERIOD;
            granted  = g ? 1 : 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (gr0) begin
                if (rep0) begin
                    if (rnd) data0 = W'($urandom);
                end else begin
                    pend0 = 1'b0;
                end
            end
            if (gr1) begin
                if (rep1) begin
                    if (rnd) data1 = W'($urandom);
                end else begin
                    pend1 = 1'b0;
                end
            end
            if (rnd) begin
                if (!pend0 && $urandom_range(3) == 0) begin
                    pend0 = 1'b1; data0 = W'($urandom);
                end else if (pend0 && $urandom_range(15) == 0) begin
                    pend0 = 1'b0;
                end
                if (!pend1 && $urandom_range(3) == 0) begin
                    pend1 = 1'b1; data1 = W'($urandom);
                end else if (pend1 && $urandom_range(15) == 0) begin
                    pend1 = 1'b0;
                end
                rep0 = 1'($urandom_range(1));
                rep1 = 1'($urandom_range(1));
            end
            rst  = force_rst | (rnd && $urandom_range(149) == 0);
            req0 = pend0;
            req1 = pend1;
            model_eval();
            gr0 = (granted == 0);
            gr1 = (granted == 1);
        end
    endtask

    // Monitor: compares what the DUT presents against the scoreboard queues.
    logic         coll = 1'b0;
    int           nbits = 0;
    logic [W-1:0] shf = '0;
    logic         cid = 1'b0;
    bit           prev_rst = 1'b0;
    always @(negedge clk) begin : monitor
        ack_t   a;
        frame_t f;
        if (mon_on) begin
            chk("ack_both", {63'd0, ack0 & ack1}, 64'd0);
            if (ack0 || ack1) begin
                obs_id.push_back(ack1 ? 1 : 0);
                obs_cyc.push_back(cyc);
                if (ackq.size() == 0) begin
                    chk("ack_unexpected", 64'd1, 64'd0);
                end else begin
                    a = ackq.pop_front();
                    chk("ack_cycle", 64'(cyc), 64'(a.c));
                    chk("ack_id", {63'd0, ack1}, {63'd0, a.id});
                end
            end else if (ackq.size() != 0 && ackq[0].c <= cyc) begin
                void'(ackq.pop_front());
                chk("ack_missing", 64'd0, 64'd1);
            end
            chk("busy", {63'd0, busy}, {63'd0, exp_busy});
            chk("sout_id", {63'd0, sout_id}, {63'd0, exp_id});
            if (sout_valid) begin
                if (sof) begin
                    if (coll) chk("sof_inside_frame", 64'd1, 64'd0);
                    coll = 1'b1; nbits = 0; shf = '0; cid = sout_id;
                    if (frameq.size() == 0) chk("frame_unexpected", 64'd1, 64'd0);
                    else chk("sof_cycle", 64'(cyc), 64'(frameq[0].c));
                end else if (!coll) begin
                    chk("bit_without_sof", 64'd1, 64'd0);
                    coll = 1'b1; nbits = 0; shf = '0; cid = sout_id;
                end
                shf = {shf[W-2:0], sout};
                nbits++;
                chk("eof_position", {63'd0, eof}, {63'd0, (nbits == W)});
                if (eof || nbits == W) begin
                    coll = 1'b0;
                    last_data = shf;
                    if (frameq.size() == 0) begin
                        chk("frame_unexpected_end", 64'd1, 64'd0);
                    end else begin
                        f = frameq.pop_front();
                        chk("frame_len", 64'(nbits), 64'(W));
                        chk("frame_id", {63'd0, cid}, {63'd0, f.id});
                        chk("frame_data", 64'(shf), 64'(f.d));
                    end
                end
            end else begin
                chk("idle_lines", {61'd0, sout, sof, eof}, 64'd0);
                if (coll) begin
                    coll = 1'b0;
                    if (prev_rst && frameq.size() > 0) void'(frameq.pop_front());
                    else chk("frame_truncated", 64'd1, 64'd0);
                end
            end
        end
        prev_rst = rst;
    end

    initial begin
        // Reset
        force_rst = 1'b1;
        run(3);
        force_rst = 1'b0;
        mon_on = 1'b1;
        run(1);
        #1;
        chk("rst_outputs", {56'd0, ack0, ack1, sout, sout_valid, sof, eof, sout_id, busy}, 64'd0);

        // Single req0 frame with 1011
        pend0 = 1'b1; data0 = 4'b1011; rep0 = 1'b0;
        obs_id.delete(); obs_cyc.delete();
        run(8);
        chk("t1_ack_count", 64'(obs_id.size()), 64'd1);
        chk("t1_data", 64'(last_data), 64'hB);
        chk("t1_idle", {63'd0, busy}, 64'd0);

        // Both held, alternating grants
        pend0 = 1'b1; pend1 = 1'b1; rep0 = 1'b1; rep1 = 1'b1;
        data0 = 4'hA; data1 = 4'h5;
        obs_id.delete(); obs_cyc.delete();
        run(4 * PERIOD);
        pend0 = 1'b0; pend1 = 1'b0; rep0 = 1'b0; rep1 = 1'b0;
        run(PERIOD + 2);
        chk("t2_ack_count", 64'(obs_id.size()), 64'd4);
        for (int k = 1; k < obs_id.size(); k++) begin
            chk("t2_alternate", {63'd0, obs_id[k] != obs_id[k-1]}, 64'd1);
            chk("t2_period", 64'(obs_cyc[k] - obs_cyc[k-1]), 64'(PERIOD));
        end

        // Only req1 pulsed, then both rise together: req0 wins
        obs_id.delete(); obs_cyc.delete();
        for (int k = 0; k < 3; k++) begin
            pend1 = 1'b1; data1 = 4'(k + 6);
            run(PERIOD);
        end
        chk("t3_req1_served", 64'(obs_id.size()), 64'd3);
        obs_id.delete(); obs_cyc.delete();
        pend0 = 1'b1; pend1 = 1'b1; data0 = 4'h3; data1 = 4'hC;
        run(2 * PERIOD + 2);
        chk("t3_first_grant", 64'(obs_id.size() > 0 ? obs_id[0] : 9), 64'd0);
        chk("t3_second_grant", 64'(obs_id.size() > 1 ? obs_id[1] : 9), 64'd1);

        // Reset during the 2nd bit of a frame
        pend0 = 1'b1; data0 = 4'hF;
        run(2);
        force_rst = 1'b1;
        run(1);
        force_rst = 1'b0;
        obs_id.delete(); obs_cyc.delete();
        pend0 = 1'b1; pend1 = 1'b1; data0 = 4'h9; data1 = 4'h6;
        run(1);
        #1;
        chk("t4_after_rst", {60'd0, sout, sout_valid, busy, eof}, 64'd0);
        chk("t4_ack0_now", {62'd0, ack0, ack1}, 64'd2);
        run(2 * PERIOD + 2);
        chk("t4_first_grant", 64'(obs_id.size() > 0 ? obs_id[0] : 9), 64'd0);

        // req1 raised during a req0 frame waits for the first IDLE after gap
        obs_id.delete(); obs_cyc.delete();
        pend0 = 1'b1; data0 = 4'h2;
        run(2);
        pend1 = 1'b1; data1 = 4'hD;
        run(2 * PERIOD);
        chk("t5_order", 64'(obs_id.size() == 2 ? obs_id[0] * 2 + obs_id[1] : 9), 64'd1);
        chk("t5_delay", 64'(obs_cyc.size() == 2 ? obs_cyc[1] - obs_cyc[0] : 0), 64'(PERIOD));

        // req0 pulsed during SHIFT and dropped before IDLE: no transfer
        obs_id.delete(); obs_cyc.delete();
        pend1 = 1'b1; data1 = 4'h7;
        run(3);
        pend0 = 1'b1; data0 = 4'hE;
        run(1);
        pend0 = 1'b0;
        run(PERIOD + 4);
        #1;
        chk("t6_ack_count", 64'(obs_id.size()), 64'd1);
        chk("t6_idle", {62'd0, busy, sout_valid}, 64'd0);

        // Randomized traffic with occasional resets
        rnd = 1'b1;
        run(3000);
        rnd = 1'b0;
        pend0 = 1'b0; pend1 = 1'b0; rep0 = 1'b0; rep1 = 1'b0;
        run(PERIOD + 4);
        chk("drain_acks", 64'(ackq.size()), 64'd0);
        chk("drain_frames", 64'(frameq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
